// File: rtl/ray_column_issuer_pkg.sv
// Shared types and default frame geometry for the ray-casting pipeline
// (column issuer, ray_calculations, dda).
package ray_column_issuer_pkg;

    localparam int SCREEN_WIDTH_DEF = 320;
    localparam int HCOUNT_W_DEF     = 9;

    typedef enum logic {
        IDLE,
        ISSUE
    } issuer_state_t;

endpackage

// File: rtl/ray_column_issuer_pose_reg.sv
// Six-field camera pose snapshot, loaded once per frame and held for the
// whole column pass.
module issuer_pose_reg #(
    parameter int POSE_W = 16
) (
    input  logic              clk_pixel,
    input  logic              rst,
    input  logic              load,
    input  logic [POSE_W-1:0] pos_x,
    input  logic [POSE_W-1:0] pos_y,
    input  logic [POSE_W-1:0] dir_x,
    input  logic [POSE_W-1:0] dir_y,
    input  logic [POSE_W-1:0] plane_x,
    input  logic [POSE_W-1:0] plane_y,
    output logic [POSE_W-1:0] pos_x_q,
    output logic [POSE_W-1:0] pos_y_q,
    output logic [POSE_W-1:0] dir_x_q,
    output logic [POSE_W-1:0] dir_y_q,
    output logic [POSE_W-1:0] plane_x_q,
    output logic [POSE_W-1:0] plane_y_q
);

    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            dir_x_q   <= '0;
            dir_y_q   <= '0;
            plane_x_q <= '0;
            plane_y_q <= '0;
        end else if (load) begin
            pos_x_q   <= pos_x;
            pos_y_q   <= pos_y;
            dir_x_q   <= dir_x;
            dir_y_q   <= dir_y;
            plane_x_q <= plane_x;
            plane_y_q <= plane_y;
        end
    end

endmodule

// File: rtl/ray_column_issuer.sv
// Issues one AXI-stream-style beat per screen column each frame, interleaved
// by STRIDE, carrying a pose snapshot that is frozen for the pass.
module ray_column_issuer
    import ray_column_issuer_pkg::*;
#(
    parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
    parameter int HCOUNT_W     = HCOUNT_W_DEF,
    parameter int POSE_W       = 16,
    parameter int STRIDE       = 1
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic                frame_start_in,
    input  logic                pose_valid_in,
    input  logic [POSE_W-1:0]   posX_in,
    input  logic [POSE_W-1:0]   posY_in,
    input  logic [POSE_W-1:0]   dirX_in,
    input  logic [POSE_W-1:0]   dirY_in,
    input  logic [POSE_W-1:0]   planeX_in,
    input  logic [POSE_W-1:0]   planeY_in,
    input  logic                ray_tready_in,
    output logic                ray_tvalid_out,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [POSE_W-1:0]   posX_out,
    output logic [POSE_W-1:0]   posY_out,
    output logic [POSE_W-1:0]   dirX_out,
    output logic [POSE_W-1:0]   dirY_out,
    output logic [POSE_W-1:0]   planeX_out,
    output logic [POSE_W-1:0]   planeY_out,
    output logic                ray_tlast_out,
    output logic                busy_out,
    output logic                overrun_out,
    output logic [7:0]          frames_dropped_out
);

    // One spare bit so idx + STRIDE past the counter range never aliases back in range.
    localparam int COL_W = HCOUNT_W + 1;

    issuer_state_t       state;
    logic [HCOUNT_W-1:0] phase;
    logic [HCOUNT_W-1:0] next_phase;
    logic [COL_W-1:0]    next_col;
    logic                pose_load;

    function automatic logic is_last(input logic [HCOUNT_W-1:0] idx);
        return ({1'b0, idx} + COL_W'(STRIDE)) >= COL_W'(SCREEN_WIDTH);
    endfunction

    assign next_col   = {1'b0, hcount_out} + COL_W'(STRIDE);
    assign next_phase = (phase == HCOUNT_W'(STRIDE - 1)) ? '0 : phase + HCOUNT_W'(1);
    assign pose_load  = (state == IDLE) && frame_start_in && pose_valid_in;
    assign busy_out   = (state == ISSUE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in the block.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state              <= IDLE;
            ray_tvalid_out     <= 1'b0;
            ray_tlast_out      <= 1'b0;
            hcount_out         <= '0;
            overrun_out        <= 1'b0;
            frames_dropped_out <= 8'd0;
            phase              <= '0;
        end else begin
            overrun_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start_in) begin
                        state          <= ISSUE;
                        ray_tvalid_out <= 1'b1;
                        hcount_out     <= phase;
                        ray_tlast_out  <= is_last(phase);
                    end
                end
                ISSUE: begin
                    // A frame start while busy is dropped, even on the tlast beat.
                    if (frame_start_in) begin
                        overrun_out <= 1'b1;
                        if (frames_dropped_out != 8'hFF)
                            frames_dropped_out <= frames_dropped_out + 8'd1;
                    end
                    if (ray_tready_in) begin
                        if (ray_tlast_out) begin
                            state          <= IDLE;
                            ray_tvalid_out <= 1'b0;
                            ray_tlast_out  <= 1'b0;
                            phase          <= next_phase;
                        end else begin
                            hcount_out    <= next_col[HCOUNT_W-1:0];
                            ray_tlast_out <= is_last(next_col[HCOUNT_W-1:0]);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    issuer_pose_reg #(
        .POSE_W (POSE_W)
    ) u_pose_reg (
        .clk_pixel (pixel_clk_in),
        .rst       (rst_in),
        .load      (pose_load),
        .pos_x     (posX_in),
        .pos_y     (posY_in),
        .dir_x     (dirX_in),
        .dir_y     (dirY_in),
        .plane_x   (planeX_in),
        .plane_y   (planeY_in),
        .pos_x_q   (posX_out),
        .pos_y_q   (posY_out),
        .dir_x_q   (dirX_out),
        .dir_y_q   (dirY_out),
        .plane_x_q (planeX_out),
        .plane_y_q (planeY_out)
    );

endmodule

// File: tb/tb_ray_column_issuer.sv
// Directed bench for ray_column_issuer: one STRIDE=1 instance and one
// STRIDE=4 instance sharing clock, reset and pose inputs.
module tb_ray_column_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs = 1'b0, fs4 = 1'b0, pv = 1'b0, rdy = 1'b0, rdy4 = 1'b0;
    logic [15:0] px = '0, py = '0, dx = '0, dy = '0, plx = '0, ply = '0;

    logic        tv, tl, bz, ov;
    logic [8:0]  hc;
    logic [7:0]  fd;
    logic [15:0] px_o, py_o, dx_o, dy_o, plx_o, ply_o;

    logic        tv4, tl4, bz4, ov4;
    logic [8:0]  hc4;
    logic [7:0]  fd4;
    logic [15:0] px4_o, py4_o, dx4_o, dy4_o, plx4_o, ply4_o;

    int total = 0;
    int bad   = 0;
    int ei;
    bit done;

    always #5 clk = ~clk;

    ray_column_issuer #(.SCREEN_WIDTH(320), .HCOUNT_W(9), .POSE_W(16), .STRIDE(1)) dut (
        .pixel_clk_in (clk), .rst_in (rst), .frame_start_in (fs), .pose_valid_in (pv),
        .posX_in (px), .posY_in (py), .dirX_in (dx), .dirY_in (dy),
        .planeX_in (plx), .planeY_in (ply), .ray_tready_in (rdy),
        .ray_tvalid_out (tv), .hcount_out (hc),
        .posX_out (px_o), .posY_out (py_o), .dirX_out (dx_o), .dirY_out (dy_o),
        .planeX_out (plx_o), .planeY_out (ply_o), .ray_tlast_out (tl),
        .busy_out (bz), .overrun_out (ov), .frames_dropped_out (fd)
    );

    ray_column_issuer #(.SCREEN_WIDTH(320), .HCOUNT_W(9), .POSE_W(16), .STRIDE(4)) dut4 (
        .pixel_clk_in (clk), .rst_in (rst), .frame_start_in (fs4), .pose_valid_in (pv),
        .posX_in (px), .posY_in (py), .dirX_in (dx), .dirY_in (dy),
        .planeX_in (plx), .planeY_in (ply), .ray_tready_in (rdy4),
        .ray_tvalid_out (tv4), .hcount_out (hc4),
        .posX_out (px4_o), .posY_out (py4_o), .dirX_out (dx4_o), .dirY_out (dy4_o),
        .planeX_out (plx4_o), .planeY_out (ply4_o), .ray_tlast_out (tl4),
        .busy_out (bz4), .overrun_out (ov4), .frames_dropped_out (fd4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_tvalid", tv, 0);
        chk("rst_tlast", tl, 0);
        chk("rst_hcount", hc, 0);
        chk("rst_busy", bz, 0);
        chk("rst_overrun", ov, 0);
        chk("rst_dropped", fd, 0);
        chk("rst_posx", px_o, 0);
        chk("rst_tvalid4", tv4, 0);
        rst = 1'b0;
        repeat (9) step();

        // Full pass, STRIDE=1, tready high: latency 1, no bubbles
        px = 16'h1234; py = 16'h5678; dx = 16'h9abc; dy = 16'hdef0; plx = 16'h0f0f; ply = 16'hf0f0;
        fs = 1'b1; pv = 1'b1; rdy = 1'b1;
        chk("t1_pre_tvalid", tv, 0);
        step();
        fs = 1'b0; pv = 1'b0;
        chk("t1_posx", px_o, 16'h1234);
        chk("t1_posy", py_o, 16'h5678);
        chk("t1_dirx", dx_o, 16'h9abc);
        chk("t1_diry", dy_o, 16'hdef0);
        chk("t1_planex", plx_o, 16'h0f0f);
        chk("t1_planey", ply_o, 16'hf0f0);
        for (int i = 0; i < 320; i++) begin
            chk("t1_tvalid", tv, 1);
            chk("t1_busy", bz, 1);
            chk("t1_hcount", hc, i);
            chk("t1_tlast", tl, i == 319);
            step();
        end
        chk("t1_end_tvalid", tv, 0);
        chk("t1_end_busy", bz, 0);
        chk("t1_end_overrun", ov, 0);

        // tready toggling every other cycle; pose captured then frozen
        px = 16'h1111; fs = 1'b1; pv = 1'b1; rdy = 1'b0;
        step();
        fs = 1'b0; pv = 1'b0; px = 16'h2222;
        ei = 0; done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            rdy = n[0];
            chk("t2_tvalid", tv, 1);
            chk("t2_hcount", hc, ei);
            chk("t2_tlast", tl, ei == 319);
            chk("t2_posx", px_o, 16'h1111);
            step();
            if (rdy) begin
                if (ei == 319) done = 1'b1;
                else ei++;
            end
        end
        chk("t2_done", done, 1);
        chk("t2_end_tvalid", tv, 0);

        // Overrun at column 100 and on the tlast beat; pose_valid low keeps snapshot
        px = 16'h3333; fs = 1'b1; pv = 1'b0; rdy = 1'b1;
        step();
        fs = 1'b0; px = 16'h4444;
        ei = 0; done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            chk("t4_tvalid", tv, 1);
            chk("t4_hcount", hc, ei);
            chk("t4_tlast", tl, ei == 319);
            chk("t4_posx", px_o, 16'h1111);
            fs = (ei == 100) || (ei == 319);
            step();
            fs = 1'b0;
            if (ei == 100) begin
                chk("t4_ovr_pulse", ov, 1);
                chk("t4_dropped1", fd, 1);
            end
            if (ei == 101) chk("t4_ovr_once", ov, 0);
            if (ei == 319) begin
                chk("t4_last_ovr", ov, 1);
                chk("t4_dropped2", fd, 2);
                chk("t4_last_tvalid", tv, 0);
                done = 1'b1;
            end else begin
                ei++;
            end
        end
        chk("t4_done", done, 1);
        step();
        chk("t4_no_reenter", tv, 0);
        chk("t4_idle_busy", bz, 0);
        chk("t4_ovr_clear", ov, 0);

        // 300 overruns saturate the drop counter
        fs = 1'b1; rdy = 1'b0;
        step();
        repeat (300) step();
        chk("t5_sat", fd, 255);
        chk("t5_ovr", ov, 1);
        fs = 1'b0;
        step();
        chk("t5_ovr_off", ov, 0);
        chk("t5_stall_hc", hc, 0);
        chk("t5_sat_hold", fd, 255);
        rdy = 1'b1;
        for (int n = 0; n < 400 && tv; n++) step();
        chk("t5_drained", tv, 0);

        // Asynchronous reset at column 50
        fs = 1'b1; rdy = 1'b1;
        step();
        fs = 1'b0;
        repeat (50) step();
        chk("t6_hc50", hc, 50);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_tvalid", tv, 0);
        chk("t6_async_tlast", tl, 0);
        chk("t6_async_hcount", hc, 0);
        chk("t6_async_busy", bz, 0);
        chk("t6_async_dropped", fd, 0);
        chk("t6_async_posx", px_o, 0);
        #1 rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            chk("t6_quiet", tv, 0);
        end
        fs = 1'b1;
        step();
        fs = 1'b0;
        chk("t6_restart_tvalid", tv, 1);
        chk("t6_restart_hc", hc, 0);
        for (int n = 0; n < 400 && tv; n++) step();
        chk("t6_drained", tv, 0);

        // STRIDE=4: phases 0,1,2,3 then back to 0
        rdy4 = 1'b1;
        for (int p = 0; p < 5; p++) begin
            fs4 = 1'b1;
            step();
            fs4 = 1'b0;
            for (int k = 0; k < 80; k++) begin
                chk("t3_tvalid", tv4, 1);
                chk("t3_hcount", hc4, (p % 4) + 4 * k);
                chk("t3_tlast", tl4, k == 79);
                step();
            end
            chk("t3_end_tvalid", tv4, 0);
            chk("t3_end_busy", bz4, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
